avst_pattern_gen: RTL and testbench
===================================

AVST_PATTERN_GEN -- requirements
Module: avst_pattern_gen

Interface
REQ-001 Parameter: LEN_W, default 16, width of the beat-count and injection-index fields.
REQ-002 clk  input  1  clock for all sequential logic.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ctl_start  input  1  single-cycle start request.
REQ-005 ctl_pattern  input  1  pattern select: 0 = counter, 1 = LFSR.
REQ-006 ctl_len  input  LEN_W  packet length in beats.
REQ-007 ctl_seed  input  32  LFSR seed, or counter start value.
REQ-008 ctl_inj_en  input  1  error-injection enable.
REQ-009 ctl_inj_beat  input  LEN_W  index of the beat to corrupt.
REQ-010 aso_out_valid  output  1  Avalon-ST source valid.
REQ-011 aso_out_ready  input  1  sink ready.
REQ-012 aso_out_data  output  128  beat data.
REQ-013 aso_out_sop  output  1  first beat of the packet.
REQ-014 aso_out_eop  output  1  last beat of the packet.
REQ-015 aso_status_data  output  4  {1'b0, one-hot state}.
REQ-016 done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-017 The block SHALL implement states IDLE=3'h1, RUN=3'h2 and DONE=3'h4.
REQ-018 In IDLE, ctl_start=1 with ctl_len!=0 SHALL latch all ctl_* inputs, clear the beat index to 0, load the generator from ctl_seed, and move to RUN on the next edge.
REQ-019 In IDLE, ctl_start=1 with ctl_len==0 SHALL be ignored: state stays IDLE and done is not pulsed.
REQ-020 ctl_start SHALL be ignored in RUN and DONE; latched configuration is immune to ctl_* changes during RUN.
REQ-021 In RUN, aso_out_valid SHALL be 1 independent of aso_out_ready, because the downstream compare sink raises ready only after seeing valid.
REQ-022 A beat SHALL be accepted on a cycle with valid=1 and ready=1; data, sop and eop SHALL hold stable while valid=1 and ready=0.
REQ-023 sop SHALL be 1 only on beat index 0, and eop SHALL be 1 only on beat index len-1; for len=1, both are 1 on the single beat.
REQ-024 Counter pattern: beat n data = {c+3, c+2, c+1, c}, where c = seed + 4n, with all 32-bit additions modulo 2^32 (wrap-around).
REQ-025 LFSR pattern: beat data = {L, ~L, L, ~L}; L = seed for beat 0, and L advances one Galois step (polynomial 0x80200003, right-shifting) per accepted beat.
REQ-026 A seed of 0 in LFSR mode SHALL be replaced by 32'h1.
REQ-027 Injection: when inj_en=1 and beat index == inj_beat, data bit 0 SHALL be inverted on that beat only.
REQ-028 Injection SHALL have no effect when inj_beat >= len.
REQ-029 Injection SHALL NOT alter the generator state, so later beats are uncorrupted.
REQ-030 Acceptance of the eop beat SHALL move RUN to DONE; valid SHALL be 0 in the following cycle.
REQ-031 DONE SHALL last exactly one cycle, assert done=1, and then return to IDLE.
REQ-032 A start can be accepted in the cycle after DONE, so the minimum inter-packet gap is 2 idle cycles.
REQ-033 Latency: the first valid beat SHALL appear one cycle after the start cycle.
REQ-034 Throughput: one beat per cycle while ready=1.
REQ-035 Beat index arithmetic SHALL be LEN_W bits wide with no overflow, since index < len <= 2^LEN_W-1.

Reset
REQ-036 While reset=1: state=IDLE; valid, sop, eop and done = 0; aso_out_data = 0; aso_status_data = 4'h1.
REQ-037 Reset mid-packet SHALL abort the packet immediately, with no eop and no done.
REQ-038 Operation after reset release SHALL require a new ctl_start.

Structure
REQ-039 Package avst_pattern_gen_pkg SHALL hold the state localparams, the LFSR polynomial constant, the pattern-select encodings and the LFSR zero-seed substitute.
REQ-040 One sub-module, avst_lfsr32, SHALL provide the load/advance 32-bit Galois LFSR register; all other logic is in the top level.

Verification
REQ-041 Counter, seed=32'h0, len=3, ready=1 -> beats {3,2,1,0}, {7,6,5,4}, {B,A,9,8}; sop on beat 0, eop on beat 2; done pulses 1 cycle after beat 2.
REQ-042 Counter, seed=32'hFFFFFFFE, len=1 -> single beat {1,0,FFFFFFFF,FFFFFFFE} with sop=eop=1.
REQ-043 LFSR, seed=0, len=2 -> beat 0 L=32'h1; beat 1 L=32'h80200003; upper/lower lanes are inverses of each other.
REQ-044 Counter, len=4, inj_en=1, inj_beat=2, ready toggling 1010... -> only beat 2 has bit 0 flipped; data stays stable during ready=0; an avst_compare fed against a clean stream ends with err_data=128'h1.
REQ-045 inj_beat=5 with len=4 -> no corrupted beat; ctl_len=0 start -> state stays 4'h1 and no done.
REQ-046 Reset asserted at beat 3 of len=8 -> valid drops to 0 immediately and no done; a new start then reproduces beat 0 exactly.

Source files
------------

// File: rtl/avst_pattern_gen_pkg.sv
// avst_pattern_gen_pkg: shared states, pattern encodings and LFSR constants
package avst_pattern_gen_pkg;
  localparam int DATA_W = 128;
  localparam logic [2:0] ST_IDLE = 3'h1;
  localparam logic [2:0] ST_RUN = 3'h2;
  localparam logic [2:0] ST_DONE = 3'h4;
  typedef enum logic [2:0] {IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE} state_t;
  localparam logic PAT_CNT = 1'b0;
  localparam logic PAT_LFSR = 1'b1;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_ZERO_SEED = 32'h0000_0001;
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ ({32{l[0]}} & LFSR_POLY);
  endfunction
endpackage

// File: rtl/avst_pattern_gen_if.sv
// avst_pattern_gen_if: Avalon-ST source/sink bundle
interface avst_pattern_gen_if;
  import avst_pattern_gen_pkg::*;
  logic valid;
  logic ready;
  logic sop;
  logic eop;
  logic [DATA_W-1:0] data;
  modport master(output valid, sop, eop, data, input ready);
  modport slave(input valid, sop, eop, data, output ready);
endinterface

// File: rtl/avst_lfsr32.sv
// avst_lfsr32: loadable right-shifting 32-bit Galois LFSR
module avst_lfsr32
  import avst_pattern_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        adv,
  input  logic [31:0] seed,
  output logic [31:0] q
);
  // load wins over advance; advance steps once per accepted beat
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (load) q <= seed;
    else if (adv) q <= lfsr_step(q);
endmodule

// File: rtl/avst_pattern_gen.sv
// avst_pattern_gen: counter/LFSR Avalon-ST packet generator with bit-0 error injection
module avst_pattern_gen
  import avst_pattern_gen_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctl_start,
  input  logic             ctl_pattern,
  input  logic [LEN_W-1:0] ctl_len,
  input  logic [31:0]      ctl_seed,
  input  logic             ctl_inj_en,
  input  logic [LEN_W-1:0] ctl_inj_beat,
  avst_pattern_gen_if.master aso_out,
  output logic [3:0]       aso_status_data,
  output logic             done
);
  state_t state, state_nxt;
  logic [LEN_W-1:0] len_q, inj_beat_q, idx;
  logic pat_q, inj_en_q, go, acc, last, inj;
  logic [31:0] cnt, lfsr, seed_eff;
  logic [DATA_W-1:0] raw;
  assign go = state == IDLE && ctl_start && ctl_len != '0;
  assign acc = aso_out.valid && aso_out.ready;
  assign last = idx == len_q - LEN_W'(1);
  assign inj = inj_en_q && idx == inj_beat_q;
  assign seed_eff = (ctl_pattern == PAT_LFSR && ctl_seed == '0) ? LFSR_ZERO_SEED : ctl_seed;
  assign raw = pat_q == PAT_LFSR ? {lfsr, ~lfsr, lfsr, ~lfsr}
                                 : {cnt + 32'd3, cnt + 32'd2, cnt + 32'd1, cnt};
  avst_lfsr32 u_lfsr (
    .clk  (clk),
    .reset(reset),
    .load (go),
    .adv  (acc),
    .seed (seed_eff),
    .q    (lfsr)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // next state and stream outputs; injection only touches the presented beat
  always_comb begin
    state_nxt = state;
    if (go) state_nxt = RUN;
    if (state == RUN && acc && last) state_nxt = DONE;
    if (state == DONE) state_nxt = IDLE;
    aso_out.valid = state == RUN;
    aso_out.sop = aso_out.valid && idx == '0;
    aso_out.eop = aso_out.valid && last;
    aso_out.data = aso_out.valid ? raw ^ {{(DATA_W-1){1'b0}}, inj} : '0;
    aso_status_data = {1'b0, state};
    done = state == DONE;
  end
  // latched configuration, beat index and counter generator
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      len_q <= '0;
      inj_beat_q <= '0;
      idx <= '0;
      pat_q <= PAT_CNT;
      inj_en_q <= 1'b0;
      cnt <= '0;
    end else if (go) begin
      len_q <= ctl_len;
      inj_beat_q <= ctl_inj_beat;
      idx <= '0;
      pat_q <= ctl_pattern;
      inj_en_q <= ctl_inj_en;
      cnt <= ctl_seed;
    end else if (acc) begin
      idx <= idx + LEN_W'(1);
      cnt <= cnt + 32'd4;
    end
endmodule

// File: tb/tb_avst_pattern_gen.sv
// tb_avst_pattern_gen: scoreboard bench with directed hand-computed packets
module tb_avst_pattern_gen;
  typedef struct packed {
    logic [127:0] data;
    logic sop;
    logic eop;
  } beat_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ctl_start = 1'b0;
  logic ctl_pattern = 1'b0;
  logic [15:0] ctl_len = '0;
  logic [31:0] ctl_seed = '0;
  logic ctl_inj_en = 1'b0;
  logic [15:0] ctl_inj_beat = '0;
  logic [3:0] status;
  logic done;
  logic rdy_toggle = 1'b0;
  logic exp_done = 1'b0;
  logic held = 1'b0;
  beat_t hold_beat;
  beat_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  avst_pattern_gen_if bus ();
  avst_pattern_gen #(.LEN_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .ctl_start      (ctl_start),
    .ctl_pattern    (ctl_pattern),
    .ctl_len        (ctl_len),
    .ctl_seed       (ctl_seed),
    .ctl_inj_en     (ctl_inj_en),
    .ctl_inj_beat   (ctl_inj_beat),
    .aso_out        (bus.master),
    .aso_status_data(status),
    .done           (done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push(input logic [127:0] d, input logic s, input logic e);
    sb.push_back('{d, s, e});
  endtask
  task automatic start(input logic pat, input logic [15:0] len, input logic [31:0] seed,
                       input logic ie, input logic [15:0] ib);
    @(posedge clk);
    #1;
    ctl_pattern = pat;
    ctl_len = len;
    ctl_seed = seed;
    ctl_inj_en = ie;
    ctl_inj_beat = ib;
    ctl_start = 1'b1;
    @(posedge clk);
    #1 ctl_start = 1'b0;
  endtask
  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
    end else begin
      chk({name, "_done_status"}, 128'(status), 128'h4);
      chk({name, "_done_valid"}, 128'(bus.valid), 128'h0);
      @(negedge clk);
      chk({name, "_idle_status"}, 128'(status), 128'h1);
      chk({name, "_sb_empty"}, 128'(sb.size()), 128'h0);
    end
  endtask
  initial begin
    bus.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.ready = rdy_toggle ? ~bus.ready : 1'b1;
    end
  end
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      chk("done_timing", 128'(done), 128'(exp_done));
      exp_done = bus.valid && bus.ready && bus.eop && !reset;
      if (held && bus.valid) begin
        chk("hold_data", bus.data, hold_beat.data);
        chk("hold_sop", 128'(bus.sop), 128'(hold_beat.sop));
        chk("hold_eop", 128'(bus.eop), 128'(hold_beat.eop));
      end
      held = 1'b0;
      if (bus.valid && bus.ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got %h expected no beat", bus.data);
        end else begin
          e = sb.pop_front();
          chk("beat_data", bus.data, e.data);
          chk("beat_sop", 128'(bus.sop), 128'(e.sop));
          chk("beat_eop", 128'(bus.eop), 128'(e.eop));
        end
      end else if (bus.valid) begin
        held = 1'b1;
        hold_beat = '{bus.data, bus.sop, bus.eop};
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(bus.valid), 128'h0);
    chk("rst_sop_eop", 128'({bus.sop, bus.eop}), 128'h0);
    chk("rst_data", bus.data, 128'h0);
    chk("rst_status", 128'(status), 128'h1);
    chk("rst_done", 128'(done), 128'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    push(128'h00000003_00000002_00000001_00000000, 1'b1, 1'b0);
    push(128'h00000007_00000006_00000005_00000004, 1'b0, 1'b0);
    push(128'h0000000B_0000000A_00000009_00000008, 1'b0, 1'b1);
    start(1'b0, 16'd3, 32'h0, 1'b0, 16'd0);
    @(negedge clk);
    chk("latency_valid", 128'(bus.valid), 128'h1);
    chk("run_status", 128'(status), 128'h2);
    wait_done("cnt3");
    push(128'h00000001_00000000_FFFFFFFF_FFFFFFFE, 1'b1, 1'b1);
    start(1'b0, 16'd1, 32'hFFFF_FFFE, 1'b0, 16'd0);
    wait_done("cnt_wrap");
    push(128'h00000001_FFFFFFFE_00000001_FFFFFFFE, 1'b1, 1'b0);
    push(128'h80200003_7FDFFFFC_80200003_7FDFFFFC, 1'b0, 1'b1);
    start(1'b1, 16'd2, 32'h0, 1'b0, 16'd0);
    wait_done("lfsr0");
    rdy_toggle = 1'b1;
    push(128'h00000013_00000012_00000011_00000010, 1'b1, 1'b0);
    push(128'h00000017_00000016_00000015_00000014, 1'b0, 1'b0);
    push(128'h0000001B_0000001A_00000019_00000019, 1'b0, 1'b0);
    push(128'h0000001F_0000001E_0000001D_0000001C, 1'b0, 1'b1);
    start(1'b0, 16'd4, 32'h10, 1'b1, 16'd2);
    @(posedge clk);
    #1;
    ctl_pattern = 1'b1;
    ctl_len = 16'd1;
    ctl_seed = 32'hDEAD_BEEF;
    ctl_inj_beat = 16'd0;
    ctl_start = 1'b1;
    @(posedge clk);
    #1 ctl_start = 1'b0;
    wait_done("inj2");
    rdy_toggle = 1'b0;
    push(128'h00000103_00000102_00000101_00000100, 1'b1, 1'b0);
    push(128'h00000107_00000106_00000105_00000104, 1'b0, 1'b0);
    push(128'h0000010B_0000010A_00000109_00000108, 1'b0, 1'b0);
    push(128'h0000010F_0000010E_0000010D_0000010C, 1'b0, 1'b1);
    start(1'b0, 16'd4, 32'h100, 1'b1, 16'd5);
    wait_done("inj_oob");
    start(1'b0, 16'd0, 32'h5, 1'b0, 16'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("len0_status", 128'(status), 128'h1);
      chk("len0_valid", 128'(bus.valid), 128'h0);
    end
    push(128'h00000023_00000022_00000021_00000020, 1'b1, 1'b0);
    push(128'h00000027_00000026_00000025_00000024, 1'b0, 1'b0);
    push(128'h0000002B_0000002A_00000029_00000028, 1'b0, 1'b0);
    start(1'b0, 16'd8, 32'h20, 1'b0, 16'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_valid", 128'(bus.valid), 128'h0);
    chk("abort_eop", 128'(bus.eop), 128'h0);
    chk("abort_data", bus.data, 128'h0);
    chk("abort_status", 128'(status), 128'h1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 128'(bus.valid), 128'h0);
      chk("post_rst_status", 128'(status), 128'h1);
    end
    chk("abort_sb_empty", 128'(sb.size()), 128'h0);
    push(128'h00000023_00000022_00000021_00000020, 1'b1, 1'b0);
    push(128'h00000027_00000026_00000025_00000024, 1'b0, 1'b1);
    start(1'b0, 16'd2, 32'h20, 1'b0, 16'd0);
    wait_done("restart");
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
